// File: rtl/pp3_sync_reset_sequencer.sv
// Reset sequencer: absorbs the async clear CLR once at the domain edge and hands
// downstream sync-only flops a registered SCLR/EN_OUT pair, plus a soft-reset handshake.
`timescale 1ns/1ps
module pp3_sync_reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       SRST_REQ,
  output logic       SCLR,
  output logic       EN_OUT,
  output logic       READY,
  output logic       SRST_ACK,
  output logic [7:0] SRST_CNT,
  output logic [2:0] dbg_state_o
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_HOLD  = 3'd1,
    ST_SHOLD = 3'd2,
    ST_ACK   = 3'd3,
    ST_RUN   = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [7:0]             srst_cnt_q, srst_cnt_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // CLR is the only async input; everything downstream of this block sees SCLR only.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q    <= ST_RESET;
      sync_q     <= '0;
      cnt_q      <= '0;
      srst_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      cnt_q      <= cnt_d;
      srst_cnt_q <= srst_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    srst_cnt_d = srst_cnt_q;
    case (state_q)
      ST_RESET: begin
        if (synced) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) state_d = ST_RUN;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_RUN: begin
        if (SRST_REQ) begin
          state_d = ST_SHOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      ST_SHOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_ACK;
          if (srst_cnt_q != 8'hFF) srst_cnt_d = srst_cnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_ACK: begin
        if (!SRST_REQ) state_d = ST_RUN;
      end
      default: state_d = ST_RESET;
    endcase
  end

  // Moore decode: outputs depend on registered state only.
  always_comb begin
    SCLR     = 1'b0;
    EN_OUT   = 1'b0;
    READY    = 1'b0;
    SRST_ACK = 1'b0;
    case (state_q)
      ST_ACK: SRST_ACK = 1'b1;
      ST_RUN: begin
        EN_OUT = 1'b1;
        READY  = 1'b1;
      end
      default: SCLR = 1'b1;
    endcase
  end

  assign SRST_CNT    = srst_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pp3_sync_reset_sequencer.sv
// Bench for pp3_sync_reset_sequencer: directed cycles push expected state/count,
// a negedge monitor pops and compares the full output set of each instance.
`timescale 1ns/1ps
module tb_pp3_sync_reset_sequencer;

  localparam logic [2:0] S_RESET = 3'd0;
  localparam logic [2:0] S_HOLD  = 3'd1;
  localparam logic [2:0] S_SHOLD = 3'd2;
  localparam logic [2:0] S_ACK   = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       clr_a, req_a, sclr_a, en_a, ready_a, ack_a;
  logic [7:0] cnt_a;
  logic [2:0] st_a;
  logic       clr_b, req_b, sclr_b, en_b, ready_b, ack_b;
  logic [7:0] cnt_b;
  logic [2:0] st_b;

  pp3_sync_reset_sequencer dut_a (
    .CLK(CLK), .CLR(clr_a), .SRST_REQ(req_a),
    .SCLR(sclr_a), .EN_OUT(en_a), .READY(ready_a), .SRST_ACK(ack_a),
    .SRST_CNT(cnt_a), .dbg_state_o(st_a)
  );

  pp3_sync_reset_sequencer #(.SYNC_STAGES(3), .HOLD_CYCLES(1)) dut_b (
    .CLK(CLK), .CLR(clr_b), .SRST_REQ(req_b),
    .SCLR(sclr_b), .EN_OUT(en_b), .READY(ready_b), .SRST_ACK(ack_b),
    .SRST_CNT(cnt_b), .dbg_state_o(st_b)
  );

  // ---------------- scoreboard ----------------
  logic [10:0] exp_q[$];
  logic [10:0] exp_b_q[$];
  string       phase = "init";
  int          checks = 0;
  int          fails  = 0;
  bit          drain  = 1'b0;

  // {SCLR, EN_OUT, READY, SRST_ACK} expected for each state
  function automatic logic [3:0] decode(input logic [2:0] st);
    case (st)
      S_ACK:   return 4'b0001;
      S_RUN:   return 4'b0110;
      default: return 4'b1000;
    endcase
  endfunction

  always @(negedge CLK) begin
    logic [10:0] e;
    logic [14:0] act, expv;
    if (exp_q.size() != 0) begin
      e    = exp_q.pop_front();
      expv = {e[10:8], decode(e[10:8]), e[7:0]};
      act  = {st_a, sclr_a, en_a, ready_a, ack_a, cnt_a};
      checks++;
      if (act !== expv) begin
        fails++;
        $display("FAIL dut_a %s @%0t: got st=%0d sclr/en/rdy/ack=%b cnt=%0d, want st=%0d sclr/en/rdy/ack=%b cnt=%0d",
                 phase, $time, act[14:12], act[11:8], act[7:0], expv[14:12], expv[11:8], expv[7:0]);
      end
    end
    if (exp_b_q.size() != 0) begin
      e    = exp_b_q.pop_front();
      expv = {e[10:8], decode(e[10:8]), e[7:0]};
      act  = {st_b, sclr_b, en_b, ready_b, ack_b, cnt_b};
      checks++;
      if (act !== expv) begin
        fails++;
        $display("FAIL dut_b %s @%0t: got st=%0d sclr/en/rdy/ack=%b cnt=%0d, want st=%0d sclr/en/rdy/ack=%b cnt=%0d",
                 phase, $time, act[14:12], act[11:8], act[7:0], expv[14:12], expv[11:8], expv[7:0]);
      end
    end
    if (drain) begin
      checks++;
      if (exp_q.size() + exp_b_q.size() != 0) begin
        fails++;
        $display("FAIL queue_drain: got %0d entries left, want 0", exp_q.size() + exp_b_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic tick_a(input logic [2:0] st, input logic [7:0] cnt);
    @(posedge CLK); #1;
    exp_q.push_back({st, cnt});
  endtask

  task automatic tick_b(input logic [2:0] st, input logic [7:0] cnt);
    @(posedge CLK); #1;
    exp_b_q.push_back({st, cnt});
  endtask

  task automatic quiet_edge();
    @(posedge CLK); #1;
  endtask

  // Seven edges after CLR falls with defaults: 2 sync, 4 hold, RUN on the 7th.
  task automatic recover_a();
    tick_a(S_RESET, 8'd0);
    tick_a(S_RESET, 8'd0);
    repeat (4) tick_a(S_HOLD, 8'd0);
    tick_a(S_RUN, 8'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clr_a = 1'b1; req_a = 1'b0;
    clr_b = 1'b1; req_b = 1'b0;

    phase = "reset_held";
    repeat (3) tick_a(S_RESET, 8'd0);
    clr_a = 1'b0;
    phase = "powerup";
    recover_a();

    phase = "soft_reset";
    req_a = 1'b1;
    tick_a(S_SHOLD, 8'd0);
    tick_a(S_SHOLD, 8'd0);
    req_a = 1'b0;
    tick_a(S_SHOLD, 8'd0);
    tick_a(S_SHOLD, 8'd0);
    tick_a(S_ACK, 8'd1);
    tick_a(S_RUN, 8'd1);

    phase = "held_req";
    req_a = 1'b1;
    repeat (4) tick_a(S_SHOLD, 8'd1);
    repeat (6) tick_a(S_ACK, 8'd2);
    req_a = 1'b0;
    tick_a(S_RUN, 8'd2);
    tick_a(S_RUN, 8'd2);

    phase = "ack_abort";
    req_a = 1'b1;
    repeat (4) tick_a(S_SHOLD, 8'd2);
    tick_a(S_ACK, 8'd3);
    quiet_edge();
    #1 clr_a = 1'b1;
    exp_q.push_back({S_RESET, 8'd0});
    #5 clr_a = 1'b0;
    phase = "req_during_hold";
    recover_a();
    tick_a(S_SHOLD, 8'd0);
    req_a = 1'b0;
    repeat (3) tick_a(S_SHOLD, 8'd0);
    tick_a(S_ACK, 8'd1);
    tick_a(S_RUN, 8'd1);

    phase = "shold_abort";
    req_a = 1'b1;
    tick_a(S_SHOLD, 8'd1);
    req_a = 1'b0;
    quiet_edge();
    #1 clr_a = 1'b1;
    exp_q.push_back({S_RESET, 8'd0});
    #5 clr_a = 1'b0;
    recover_a();

    phase = "saturation";
    for (int k = 1; k <= 260; k++) begin
      logic [7:0] before_cnt, after_cnt;
      before_cnt = (k - 1 > 255) ? 8'd255 : 8'(k - 1);
      after_cnt  = (k > 255) ? 8'd255 : 8'(k);
      req_a = 1'b1;
      tick_a(S_SHOLD, before_cnt);
      req_a = 1'b0;
      repeat (3) tick_a(S_SHOLD, before_cnt);
      tick_a(S_ACK, after_cnt);
      tick_a(S_RUN, after_cnt);
    end

    phase = "b_clr_held";
    tick_b(S_RESET, 8'd0);
    clr_b = 1'b0;
    phase = "b_powerup";
    repeat (3) tick_b(S_RESET, 8'd0);
    tick_b(S_HOLD, 8'd0);
    tick_b(S_RUN, 8'd0);

    phase = "b_glitch";
    quiet_edge();
    #1 clr_b = 1'b1;
    #1 clr_b = 1'b0;
    exp_b_q.push_back({S_RESET, 8'd0});
    repeat (3) tick_b(S_RESET, 8'd0);
    tick_b(S_HOLD, 8'd0);
    tick_b(S_RUN, 8'd0);

    phase = "b_soft_reset";
    req_b = 1'b1;
    tick_b(S_SHOLD, 8'd0);
    tick_b(S_ACK, 8'd1);
    req_b = 1'b0;
    tick_b(S_RUN, 8'd1);

    phase = "drain";
    drain = 1'b1;
  end

endmodule
